// File: rtl/multdiv_ctrl_if.sv
// rtl/multdiv_ctrl_if.sv - pipeline/multdiv handshake bundle for multdiv_ctrl
interface multdiv_ctrl_if;
  logic        dx_isMul;
  logic        dx_isDiv;
  logic [4:0]  dx_rd;
  logic [31:0] dx_a;
  logic [31:0] dx_b;
  logic        flush;
  logic        md_resultRDY;
  logic        md_exception;
  logic [31:0] md_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // pipeline and multdiv unit side
  modport master (
    output dx_isMul, dx_isDiv, dx_rd, dx_a, dx_b, flush,
    output md_resultRDY, md_exception, md_result,
    input  ctrl_MULT, ctrl_DIV, md_a, md_b, stall, wb_valid, wb_rd, wb_data
  );

  // controller side
  modport slave (
    input  dx_isMul, dx_isDiv, dx_rd, dx_a, dx_b, flush,
    input  md_resultRDY, md_exception, md_result,
    output ctrl_MULT, ctrl_DIV, md_a, md_b, stall, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - sequences a multi-cycle mul/div and its register writeback
module multdiv_ctrl #(
  parameter int         TIMEOUT  = 40,
  parameter logic [4:0] MUL_CODE = 5'd4,
  parameter logic [4:0] DIV_CODE = 5'd5
) (
  input logic            clock,
  input logic            reset,
  multdiv_ctrl_if.slave  bus
);

  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_mul;
  logic [4:0]    rd_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          mult_q;
  logic          div_q;
  logic          wb_valid_q;
  logic [4:0]    wb_rd_q;
  logic [31:0]   wb_data_q;
  logic          request;

  assign request = bus.dx_isMul | bus.dx_isDiv;

  // stall drops immediately on reset and in any flush cycle so the pipeline can redirect
  assign bus.stall = ~reset & ~bus.flush &
                     ((state == IDLE & request) | state == START | state == BUSY);

  assign bus.ctrl_MULT = mult_q;
  assign bus.ctrl_DIV  = div_q;
  assign bus.md_a      = a_q;
  assign bus.md_b      = b_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;

  // control FSM with registered start pulses and writeback outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      is_mul     <= 1'b0;
      rd_q       <= 5'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (request && !bus.flush) begin
            // mul wins when the decoder flags both
            is_mul <= bus.dx_isMul;
            rd_q   <= bus.dx_rd;
            a_q    <= bus.dx_a;
            b_q    <= bus.dx_b;
            mult_q <= bus.dx_isMul;
            div_q  <= ~bus.dx_isMul;
            state  <= START;
          end
        end
        START: begin
          // the start pulse lasts this cycle only; any early RDY is ignored
          mult_q <= 1'b0;
          div_q  <= 1'b0;
          cnt    <= '0;
          state  <= bus.flush ? IDLE : BUSY;
        end
        BUSY: begin
          if (bus.flush) begin
            state <= IDLE;
          end else if (bus.md_resultRDY || cnt == CNT_MAX) begin
            state <= DONE;
            if (!bus.md_resultRDY || bus.md_exception) begin
              // exceptions (including timeout) report the cause code in r30
              wb_valid_q <= 1'b1;
              wb_rd_q    <= 5'd30;
              wb_data_q  <= {27'd0, (is_mul ? MUL_CODE : DIV_CODE)};
            end else begin
              // writes to r0 are suppressed and leave the outputs at zero
              wb_valid_q <= (rd_q != 5'd0);
              wb_rd_q    <= rd_q;
              wb_data_q  <= (rd_q != 5'd0) ? bus.md_result : 32'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // writeback is committed regardless of flush; new requests wait for IDLE
          wb_valid_q <= 1'b0;
          wb_rd_q    <= 5'd0;
          wb_data_q  <= 32'd0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
